shift_arbiter: RTL

//   Shares one combinational 16-bit shift_right unit between two requesters.

---
 rtl/shift_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational shift_right unit between two
// requesters; the shifted result is held in a one-entry valid/ready output register.
module shift_arbiter #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [SHW-1:0]   req0_amt,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [SHW-1:0]   req1_amt,
   input  logic [WIDTH-1:0] req1_data,
   output logic [SHW-1:0]   sh_s,
   output logic [WIDTH-1:0] sh_din,
   input  logic [WIDTH-1:0] sh_dout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             pri_r;
   logic             rsp_id_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             can_accept_s;
   logic             gnt0_s;
   logic             gnt1_s;
   logic             any_gnt_s;

   // Grant logic; pri_r is the last winner, so the other requester wins a tie
   always_comb begin
      can_accept_s = 1'b0;
      gnt0_s       = 1'b0;
      gnt1_s       = 1'b0;
      if (reset) begin
         can_accept_s = 1'b0;
      end else begin
         can_accept_s = (state_r == ST_EMPTY) | rsp_ready;
      end
      gnt0_s    = can_accept_s & req0_valid & (~req1_valid | (pri_r == 1'b1));
      gnt1_s    = can_accept_s & req1_valid & (~req0_valid | (pri_r == 1'b0));
      any_gnt_s = gnt0_s | gnt1_s;
   end

   // Shifter operand mux: granted request drives the shared unit, else zeros
   always_comb begin
      sh_s   = {SHW{1'b0}};
      sh_din = {WIDTH{1'b0}};
      if (gnt0_s) begin
         sh_s   = req0_amt;
         sh_din = req0_data;
      end else if (gnt1_s) begin
         sh_s   = req1_amt;
         sh_din = req1_data;
      end else begin
         sh_s   = {SHW{1'b0}};
         sh_din = {WIDTH{1'b0}};
      end
   end

   // Result-register occupancy next state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (any_gnt_s) begin
               state_nxt_s = ST_FULL;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (rsp_ready && !any_gnt_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State register, result capture and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_EMPTY;
         pri_r      <= 1'b1;
         rsp_id_r   <= 1'b0;
         rsp_data_r <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (any_gnt_s) begin
            rsp_data_r <= sh_dout;
            rsp_id_r   <= gnt1_s;
            pri_r      <= gnt1_s;
         end
      end
   end

   assign req0_ready = gnt0_s;
   assign req1_ready = gnt1_s;
   assign rsp_valid  = (state_r == ST_FULL);
   assign rsp_id     = rsp_id_r;
   assign rsp_data   = rsp_data_r;

endmodule
